// File: rtl/eeprom_page_core.sv
// Storage core of the I2C EEPROM slave model: byte array, row/column pointer,
// page write buffer with in-page wrap, and a write-cycle FSM modelling tWR.
module eeprom_page_core #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int PAGE_W    = 3,
    parameter int WR_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     addr_load,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic                     commit,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     ovf,
    output logic [ADDR_W-PAGE_W-1:0] row,
    output logic [PAGE_W-1:0]        col,
    output logic [1:0]               dbg_state
);

    localparam int PAGE_N = 1 << PAGE_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(WR_CYCLES + 1);
    localparam logic [PAGE_W:0]   WCNT_FULL = (PAGE_W+1)'(PAGE_N);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WR_CYCLES);
    localparam logic [PAGE_W-1:0] K_LAST    = PAGE_W'(PAGE_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROG = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]   r_buf [0:PAGE_N-1];
    logic [ADDR_W-1:0]   r_ptr;
    logic [PAGE_N-1:0]   r_en;
    logic [PAGE_W:0]     r_wcnt;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_busy;
    logic [PAGE_W-1:0]   r_k;
    logic [CNT_W-1:0]    r_wait;

    logic                w_dirty;
    logic                w_do_load;
    logic                w_do_write;
    logic                w_do_read;
    logic                w_do_start;
    logic                w_prog_we;
    logic                w_prog_last;
    logic                w_wait_done;
    logic [ADDR_W-PAGE_W-1:0] w_row;
    logic [PAGE_W-1:0]   w_col;

    assign w_dirty = |r_en;
    assign w_row   = r_ptr[ADDR_W-1:PAGE_W];
    assign w_col   = r_ptr[PAGE_W-1:0];

    // IDLE arbitrates one command per cycle; PROG/WAIT ignore every strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_write  = 1'b0;
        w_do_read   = 1'b0;
        w_do_start  = 1'b0;
        w_prog_we   = 1'b0;
        w_prog_last = 1'b0;
        w_wait_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (addr_load) begin
                    w_do_load = 1'b1;
                end else if (commit) begin
                    if (w_dirty) begin
                        w_do_start  = 1'b1;
                        w_state_nxt = S_PROG;
                    end
                end else if (wr_en) begin
                    w_do_write = 1'b1;
                end else if (rd_en && !w_dirty) begin
                    w_do_read = 1'b1;
                end
            end
            S_PROG: begin
                w_prog_we = r_en[r_k];
                if (r_k == K_LAST) begin
                    w_prog_last = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == CNT_W'(1)) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_en       <= '0;
            r_wcnt     <= '0;
            r_ovf      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_k        <= '0;
            r_wait     <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_do_load) begin
                r_ptr  <= addr_i;
                r_en   <= '0;
                r_wcnt <= '0;
                r_ovf  <= 1'b0;
            end
            if (w_do_write) begin
                r_en[w_col]          <= 1'b1;
                r_ptr[PAGE_W-1:0]    <= w_col + 1'b1;
                if (r_wcnt == WCNT_FULL) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
            if (w_do_read) begin
                r_rd_data  <= r_mem[r_ptr];
                r_rd_valid <= 1'b1;
                r_ptr      <= r_ptr + 1'b1;
            end
            if (w_do_start) begin
                r_k <= '0;
            end
            if (r_state == S_PROG) begin
                r_k <= r_k + 1'b1;
            end
            if (w_prog_last) begin
                r_wait <= WAIT_LOAD;
            end
            if (r_state == S_WAIT) begin
                r_wait <= r_wait - 1'b1;
            end
            if (w_wait_done) begin
                r_en   <= '0;
                r_wcnt <= '0;
            end
        end
    end

    // Array and buffer data are not reset; only their control state is.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_buf[w_col] <= wr_data;
        end
        if (w_prog_we) begin
            r_mem[{w_row, r_k}] <= r_buf[r_k];
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = r_busy;
    assign ovf       = r_ovf;
    assign row       = w_row;
    assign col       = w_col;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_eeprom_page_core.sv
// Randomised bench for eeprom_page_core: array/pointer/page model with an
// expected-read queue drained by a monitor on rd_valid.
module tb_eeprom_page_core;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int PAGE_W    = 3;
  localparam int WR_CYCLES = 4;
  localparam int PAGE      = 1 << PAGE_W;
  localparam int DEPTH     = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     addr_load = 1'b0;
  logic [ADDR_W-1:0]        addr_i = '0;
  logic                     wr_en = 1'b0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     rd_en = 1'b0;
  logic                     commit = 1'b0;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     ovf;
  logic [ADDR_W-PAGE_W-1:0] row;
  logic [PAGE_W-1:0]        col;
  logic [1:0]               dbg_state;

  eeprom_page_core #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .WR_CYCLES(WR_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_load(addr_load), .addr_i(addr_i),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .commit(commit),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .ovf(ovf),
    .row(row), .col(col), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // reference model
  int  m_mem [DEPTH];
  int  m_buf [PAGE];
  bit  m_en  [PAGE];
  int  m_ptr;
  int  m_cnt;
  bit  m_ovf;

  logic [DATA_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %0h required no read (t=%0t)", rd_data, $time);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  function automatic bit m_dirty();
    for (int c = 0; c < PAGE; c++) if (m_en[c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    addr_load = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic do_op(input bit ld, input bit cm, input bit wr, input bit rd,
                       input logic [7:0] a, input logic [7:0] d, input bit inject);
    bit start;
    int n;
    int rw;
    int cl;
    addr_load = ld; addr_i = a; commit = cm; wr_en = wr; wr_data = d; rd_en = rd;
    tick();
    clear_strobes();
    start = 1'b0;
    rw = m_ptr / PAGE;
    cl = m_ptr % PAGE;
    if (ld) begin
      m_ptr = a;
      for (int c = 0; c < PAGE; c++) m_en[c] = 1'b0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (cm) begin
      start = m_dirty();
    end else if (wr) begin
      m_buf[cl] = d;
      m_en[cl]  = 1'b1;
      if (m_cnt == PAGE) m_ovf = 1'b1;
      else m_cnt++;
      m_ptr = rw * PAGE + (cl + 1) % PAGE;
    end else if (rd && !m_dirty()) begin
      exp_q.push_back(8'(m_mem[m_ptr]));
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    if (start) begin
      n = 0;
      while (busy === 1'b1 && n < 64) begin
        n++;
        if (inject) begin
          addr_load = (n == 2);
          addr_i    = 8'($urandom_range(0, 255));
          wr_en     = (n == 4);
          wr_data   = 8'($urandom_range(0, 255));
          rd_en     = (n == 6);
        end
        tick();
        clear_strobes();
      end
      check("busy_len", n, PAGE + WR_CYCLES);
      for (int c = 0; c < PAGE; c++) begin
        if (m_en[c]) m_mem[rw * PAGE + c] = m_buf[c];
        m_en[c] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      check("busy_idle", busy, 1'b0);
    end
    check("ptr", {row, col}, m_ptr);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic load(input logic [7:0] a);  do_op(1, 0, 0, 0, a, 8'h00, 0); endtask
  task automatic write(input logic [7:0] d); do_op(0, 0, 1, 0, 8'h00, d, 0); endtask
  task automatic read();                     do_op(0, 0, 0, 1, 8'h00, 8'h00, 0); endtask
  task automatic cmt(input bit inj);         do_op(0, 1, 0, 0, 8'h00, 8'h00, inj); endtask

  task automatic check_reset_outputs();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
  endtask

  initial begin
    int r;
    m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
    for (int c = 0; c < PAGE; c++) begin m_en[c] = 1'b0; m_buf[c] = 0; end

    // power-on reset
    tick();
    tick();
    check_reset_outputs();
    #2 rst_n = 1'b1;
    tick();

    // give every array byte a known value through the page path
    for (int p = 0; p < DEPTH / PAGE; p++) begin
      load(8'(p * PAGE));
      for (int c = 0; c < PAGE; c++) write(8'($urandom_range(0, 255)));
      cmt(0);
    end

    // basic page write
    load(8'h13);
    write(8'hA1); write(8'hA2); write(8'hA3);
    cmt(0);
    load(8'h13);
    read(); read(); read();
    check("basic_ptr", {row, col}, 8'h16);

    // in-page wrap
    load(8'h1E);
    write(8'hB0); write(8'hB1); write(8'hB2); write(8'hB3);
    check("wrap_row", row, 3);
    check("wrap_col", col, 2);
    cmt(0);
    load(8'h18);
    read(); read(); read();
    load(8'h1E);
    read(); read();

    // overflow
    load(8'h20);
    for (int i = 0; i < 9; i++) write(8'(8'hC0 + i));
    check("ovf_set", ovf, 1'b1);
    cmt(0);
    check("ovf_persist", ovf, 1'b1);
    load(8'h20);
    check("ovf_clear", ovf, 1'b0);
    for (int i = 0; i < PAGE; i++) read();

    // read wrap, then a dirty buffer blocks reads
    load(8'hFF);
    read(); read();
    check("rdwrap_ptr", {row, col}, 8'h01);
    write(8'h5A);
    read();
    cmt(0);

    // strobes while busy are ignored
    load(8'h40);
    for (int i = 0; i < 4; i++) write(8'($urandom_range(0, 255)));
    cmt(1);
    load(8'h40);
    for (int i = 0; i < 5; i++) read();

    // priority with simultaneous strobes
    load(8'h50);
    do_op(0, 0, 1, 1, 8'h00, 8'h77, 0);
    do_op(1, 0, 1, 0, 8'h58, 8'h66, 0);
    do_op(0, 1, 1, 0, 8'h00, 8'h55, 0);
    write(8'h44);
    do_op(0, 1, 1, 1, 8'h00, 8'h33, 0);
    do_op(0, 0, 0, 1, 8'h00, 8'h00, 0);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       load(8'($urandom_range(0, 255)));
      else if (r < 55) write(8'($urandom_range(0, 255)));
      else if (r < 80) read();
      else if (r < 90) cmt($urandom_range(0, 1) == 1);
      else do_op($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    end
    if (m_dirty()) cmt(0);

    // reset abort in PROG at k=3
    load(8'h60);
    read(); read();
    load(8'h68);
    for (int i = 0; i < 9; i++) write(8'($urandom_range(0, 255)));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("abort_busy", busy, 1'b1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int c = 0; c < PAGE; c++) begin
      if (c < 3) m_mem[8'h68 + c] = m_buf[c];
      m_en[c] = 1'b0;
    end
    m_cnt = 0; m_ovf = 1'b0; m_ptr = 0;
    #2 rst_n = 1'b1;
    tick();
    cmt(0);
    load(8'h68);
    for (int i = 0; i < PAGE; i++) read();

    tick(); tick(); tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
